// File: rtl/multicycle_control_if.sv
// Control <-> datapath bundle for the multicycle controller: opcode/handshake/flag in,
// strobes, selects, state, retired count and trap indication out.
interface multicycle_control_if #(parameter int CNT_W = 32);
  logic [6:0]       Opcode;
  logic             mem_ready;
  logic             Zero;
  logic             PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite;
  logic             MemtoReg, RegWrite, ALUSrcA, PCSource;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;
  logic             trap;

  modport master (
    input  Opcode, mem_ready, Zero,
    output PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
           MemtoReg, RegWrite, ALUSrcA, PCSource, ALUSrcB, ALUOp,
           state, instr_count, trap
  );

  modport slave (
    output Opcode, mem_ready, Zero,
    input  PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
           MemtoReg, RegWrite, ALUSrcA, PCSource, ALUSrcB, ALUOp,
           state, instr_count, trap
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM controller for a FETCH/DECODE/EXEC/MEM/WB multicycle datapath with a retired counter.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes lock into TRAP instead of retiring as NOPs.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  multicycle_control_if.master bus
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R   = 7'd51;
  localparam logic [6:0] OP_LD  = 7'd3;
  localparam logic [6:0] OP_SD  = 7'd35;
  localparam logic [6:0] OP_BEQ = 7'd99;

  state_t           r_state, w_next;
  logic [6:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             w_retire;
  logic             w_known;
  logic             w_unused_zero;

  // Zero only qualifies the PC load inside the datapath (PCWriteCond & Zero).
  assign w_unused_zero = bus.Zero;

  assign w_known = (bus.Opcode == OP_R) || (bus.Opcode == OP_LD) ||
                   (bus.Opcode == OP_SD) || (bus.Opcode == OP_BEQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_op    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= bus.Opcode;
      if (w_retire)            r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH:  if (bus.mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        if (w_known) begin
          w_next = S_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          w_next = S_TRAP;
`else
          w_next   = S_FETCH;
          w_retire = 1'b1;
`endif
        end
      end
      S_EXEC: begin
        case (r_op)
          OP_R:         w_next = S_WB;
          OP_LD, OP_SD: w_next = S_MEM;
          default: begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          if (r_op == OP_LD) begin
            w_next = S_WB;
          end else begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
        end
      end
      S_WB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   w_next = S_TRAP;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.PCSource    = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    case (r_state)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        // Reset holds state in FETCH; keep IR and PC frozen while it is asserted.
        bus.IRWrite = bus.mem_ready & rst_n;
        bus.PCWrite = bus.mem_ready & rst_n;
      end
      S_DECODE: bus.ALUSrcB = 2'b10;
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        case (r_op)
          OP_R:         bus.ALUOp   = 2'b10;
          OP_LD, OP_SD: bus.ALUSrcB = 2'b10;
          OP_BEQ: begin
            bus.ALUOp       = 2'b01;
            bus.PCWriteCond = 1'b1;
            bus.PCSource    = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        bus.IorD     = 1'b1;
        bus.MemRead  = (r_op == OP_LD);
        bus.MemWrite = (r_op == OP_SD);
      end
      S_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = (r_op == OP_LD);
      end
      default: ;
    endcase
  end

  assign bus.state       = r_state;
  assign bus.instr_count = r_cnt;
`ifdef ILLEGAL_TRAP_EN
  assign bus.trap = (r_state == S_TRAP);
`else
  assign bus.trap = 1'b0;
`endif
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: CNT_W, default 32, width of retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 Opcode  input  7  opcode field from instruction register, valid from DECODE onward.
REQ-005 mem_ready  input  1  memory handshake; access completes in the cycle it is 1.
REQ-006 Zero  input  1  ALU zero flag.
REQ-007 PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrcA, PCSource  output  1 each  datapath strobes/selects.
REQ-008 ALUSrcB  output  2  00 register, 01 constant 4, 10 immediate.
REQ-009 ALUOp  output  2  00 add, 01 subtract/compare, 10 funct-decoded.
REQ-010 state  output  3  current FSM state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-011 instr_count  output  CNT_W  retired-instruction count.
REQ-012 trap  output  1  illegal-opcode indication.

Function
REQ-013 All outputs SHALL be Moore-decoded from state and the opcode latched in DECODE (op_q), except where a term below names mem_ready or Zero.
REQ-014 Unlisted strobes SHALL be 0 in every state; ALUSrcB, ALUOp default 00.
REQ-015 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, IRWrite=PCWrite=mem_ready; stay while mem_ready=0, else go to DECODE.
REQ-016 DECODE: latch op_q<=Opcode; ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target); go to EXEC for opcodes 51, 3, 35, 99, else per REQ-027/028.
REQ-017 EXEC R-type (51): ALUSrcA=1, ALUSrcB=00, ALUOp=10; next WB.
REQ-018 EXEC ld (3) / sd (35): ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEM.
REQ-019 EXEC beq (99): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1; PC loads only when Zero=1; next FETCH, instruction retires.
REQ-020 MEM ld: MemRead=1, IorD=1; hold until mem_ready=1, then WB.
REQ-021 MEM sd: MemWrite=1, IorD=1; hold until mem_ready=1, then FETCH, instruction retires.
REQ-022 WB: RegWrite=1, MemtoReg=1 for ld else 0; next FETCH, instruction retires.
REQ-023 Zero-wait-state latency SHALL be beq 3, R-type 4, sd 4, ld 5 cycles; each mem_ready=0 cycle in FETCH/MEM adds exactly one.
REQ-024 instr_count SHALL increment by 1 on the edge leaving the retiring state, wrapping from all-ones to 0 without flag.
REQ-025 MemRead and MemWrite SHALL never be 1 in the same cycle.

Reset
REQ-026 rst_n=0 SHALL immediately force state=FETCH, op_q=0, instr_count=0, trap=0, all strobes per FETCH with mem_ready ignored (IRWrite=PCWrite=0 while in reset); a mid-instruction reset abandons the instruction without retiring it.

Configuration
REQ-027 With ILLEGAL_TRAP_EN defined: unknown opcode in DECODE SHALL enter TRAP, assert trap=1 with all strobes 0, and remain until reset.
REQ-028 Without ILLEGAL_TRAP_EN: unknown opcode SHALL return DECODE->FETCH as a NOP, count as retired, trap tied 0, TRAP state unreachable.

Verification
REQ-029 Reset then R-type (51), mem_ready=1 always -> states 0,1,2,4,0; RegWrite=1 only in WB; instr_count=1.
REQ-030 ld (3) with mem_ready low 2 cycles in MEM -> MEM held 3 cycles, MemRead=IorD=1 throughout, WB has MemtoReg=1; total 7 cycles.
REQ-031 beq (99) with Zero=1 then Zero=0 -> PCWriteCond=1 in EXEC both times, 3 cycles each, instr_count=2.
REQ-032 sd (35) -> MemWrite=1 only in MEM, RegWrite never 1, back to FETCH after 4 cycles.
REQ-033 Opcode 7'h7F: with ILLEGAL_TRAP_EN -> state=5, trap=1 held 10 cycles; without -> FETCH next cycle, instr_count+1.
REQ-034 rst_n asserted during MEM of ld -> state=0 asynchronously, no RegWrite, instr_count=0; CNT_W=4 run of 16 beq -> count wraps to 0.
